// File: rtl/seq_learning_neuron.sv
// Serial learning neuron: N weights plus bias in registers, one multiply-accumulate
// per clock for the forward pass and one weight update per clock for training.
module seq_learning_neuron #(
  parameter  int N        = 32,
  parameter  int W        = 16,
  parameter  int FRAC     = 8,
  parameter  int ACT_RELU = 1,
  parameter  int LRS_W    = 4,
  localparam int AW       = $clog2(N + 1)
) (
  input  logic             sln_clock,
  input  logic             sln_reset_n,
  input  logic [N*W-1:0]   sln_dendrites,
  input  logic             sln_fwd_start,
  output logic [W-1:0]     sln_axon,
  output logic             sln_axon_valid,
  input  logic [W-1:0]     sln_backprop,
  input  logic [LRS_W-1:0] sln_lr_shift,
  input  logic             sln_train_start,
  output logic [N*W-1:0]   sln_backprop_change,
  output logic             sln_train_done,
  output logic             sln_busy,
  input  logic             sln_wr_en,
  input  logic [AW-1:0]    sln_wr_addr,
  input  logic [W-1:0]     sln_wr_data
);

  localparam int PW    = 2 * W;
  localparam int ACC_W = 2 * W + AW;

  // Handshake: a start or write is accepted only on an edge where the neuron is
  // idle (sln_busy low); results are announced by one-cycle valid/done pulses.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FWD       = 3'd1,
    FWD_OUT   = 3'd2,
    TRAIN     = 3'd3,
    TRAIN_OUT = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic        [AW-1:0]      idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [W-1:0]       w_q   [0:N];
  logic signed [W-1:0]       w_d   [0:N];
  logic signed [W-1:0]       x_q   [0:N-1];
  logic signed [W-1:0]       x_d   [0:N-1];
  logic signed [W-1:0]       chg_q [0:N-1];
  logic signed [W-1:0]       chg_d [0:N-1];
  logic signed [W-1:0]       err_q, err_d;
  logic        [LRS_W-1:0]   lrs_q, lrs_d;
  logic        [W-1:0]       axon_q, axon_d;
  logic                      valid_q, valid_d;
  logic                      done_q, done_d;
  logic        [N*W-1:0]     chg_out_q, chg_out_d;

  // Clamp a wide signed value to the W-bit range.
  function automatic logic signed [W-1:0] sat_w(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-W:0] top;
    top = v[ACC_W-1:W-1];
    if ((&top) || !(|top)) begin
      sat_w = v[W-1:0];
    end else if (v[ACC_W-1]) begin
      sat_w = {1'b1, {(W-1){1'b0}}};
    end else begin
      sat_w = {1'b0, {(W-1){1'b1}}};
    end
  endfunction

  logic                    idx_lt_n;
  logic signed [W-1:0]     x_cur, w_cur;
  logic signed [PW-1:0]    prod_xw, prod_we, prod_xe;
  logic signed [PW-1:0]    fwd_term, chg_term, step_term;
  logic signed [W-1:0]     bias_step;
  logic signed [ACC_W-1:0] fwd_add, upd_w, upd_b, acc_sat_in;
  logic signed [W-1:0]     acc_sat;

  always_comb begin
    idx_lt_n  = (idx_q < AW'(N));
    x_cur     = idx_lt_n ? x_q[idx_q] : '0;
    w_cur     = w_q[idx_q];
    prod_xw   = $signed({{W{x_cur[W-1]}}, x_cur}) * $signed({{W{w_cur[W-1]}}, w_cur});
    prod_we   = $signed({{W{w_cur[W-1]}}, w_cur}) * $signed({{W{err_q[W-1]}}, err_q});
    prod_xe   = $signed({{W{x_cur[W-1]}}, x_cur}) * $signed({{W{err_q[W-1]}}, err_q});
    fwd_term  = prod_xw >>> FRAC;
    chg_term  = prod_we >>> FRAC;
    // Two arithmetic shifts compose to a single floor shift by FRAC + lr_shift.
    step_term = (prod_xe >>> FRAC) >>> lrs_q;
    bias_step = err_q >>> lrs_q;
    fwd_add   = idx_lt_n ? {{AW{fwd_term[PW-1]}}, fwd_term}
                         : {{(ACC_W-W){w_cur[W-1]}}, w_cur};
    upd_w     = {{(ACC_W-W){w_cur[W-1]}}, w_cur} - {{AW{step_term[PW-1]}}, step_term};
    upd_b     = {{(ACC_W-W){w_cur[W-1]}}, w_cur} - {{(ACC_W-W){bias_step[W-1]}}, bias_step};
    acc_sat_in = acc_q;
    acc_sat   = sat_w(acc_sat_in);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    w_d       = w_q;
    x_d       = x_q;
    chg_d     = chg_q;
    err_d     = err_q;
    lrs_d     = lrs_q;
    axon_d    = axon_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    chg_out_d = chg_out_q;

    unique case (state_q)
      IDLE: begin
        if (sln_fwd_start) begin
          for (int i = 0; i < N; i++) begin
            x_d[i] = sln_dendrites[i*W +: W];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = FWD;
        end else if (sln_train_start) begin
          err_d   = sln_backprop;
          lrs_d   = sln_lr_shift;
          idx_d   = '0;
          state_d = TRAIN;
        end else if (sln_wr_en && (sln_wr_addr <= AW'(N))) begin
          w_d[sln_wr_addr] = sln_wr_data;
        end
      end

      FWD: begin
        acc_d = acc_q + fwd_add;
        if (idx_lt_n) begin
          idx_d = idx_q + 1'b1;
        end else begin
          idx_d   = '0;
          state_d = FWD_OUT;
        end
      end

      FWD_OUT: begin
        if ((ACT_RELU != 0) && acc_sat[W-1]) begin
          axon_d = '0;
        end else begin
          axon_d = acc_sat;
        end
        valid_d = 1'b1;
        state_d = IDLE;
      end

      TRAIN: begin
        if (idx_lt_n) begin
          chg_d[idx_q[AW-1:0]] = sat_w({{AW{chg_term[PW-1]}}, chg_term});
          w_d[idx_q]           = sat_w(upd_w);
          idx_d                = idx_q + 1'b1;
        end else begin
          w_d[idx_q] = sat_w(upd_b);
          idx_d      = '0;
          state_d    = TRAIN_OUT;
        end
      end

      TRAIN_OUT: begin
        for (int i = 0; i < N; i++) begin
          chg_out_d[i*W +: W] = chg_q[i];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sln_clock or negedge sln_reset_n) begin
    if (!sln_reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      err_q     <= '0;
      lrs_q     <= '0;
      axon_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      chg_out_q <= '0;
      for (int i = 0; i <= N; i++) begin
        w_q[i] <= '0;
      end
      for (int i = 0; i < N; i++) begin
        x_q[i]   <= '0;
        chg_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      err_q     <= err_d;
      lrs_q     <= lrs_d;
      axon_q    <= axon_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      chg_out_q <= chg_out_d;
      w_q       <= w_d;
      x_q       <= x_d;
      chg_q     <= chg_d;
    end
  end

  assign sln_axon            = axon_q;
  assign sln_axon_valid      = valid_q;
  assign sln_train_done      = done_q;
  assign sln_backprop_change = chg_out_q;
  assign sln_busy            = (state_q != IDLE);

endmodule

// File: tb/tb_seq_learning_neuron.sv
// Bench for seq_learning_neuron: a ReLU and an identity instance share all inputs
// and are checked against an integer model of the neuron's arithmetic.
module tb_seq_learning_neuron;
  localparam int N     = 4;
  localparam int W     = 16;
  localparam int FRAC  = 8;
  localparam int LRS_W = 4;
  localparam int AW    = $clog2(N + 1);
  localparam int LAT   = N + 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N*W-1:0]   dendrites;
  logic             fwd_start, train_start, wr_en;
  logic [W-1:0]     backprop, wr_data;
  logic [LRS_W-1:0] lr_shift;
  logic [AW-1:0]    wr_addr;
  logic [W-1:0]     axon_r, axon_i;
  logic             valid_r, valid_i, done_r, done_i, busy_r, busy_i;
  logic [N*W-1:0]   chg_r, chg_i;

  always #5 clk = ~clk;

  seq_learning_neuron #(.N(N), .W(W), .FRAC(FRAC), .ACT_RELU(1), .LRS_W(LRS_W)) dut_r (
    .sln_clock(clk), .sln_reset_n(rst_n), .sln_dendrites(dendrites),
    .sln_fwd_start(fwd_start), .sln_axon(axon_r), .sln_axon_valid(valid_r),
    .sln_backprop(backprop), .sln_lr_shift(lr_shift), .sln_train_start(train_start),
    .sln_backprop_change(chg_r), .sln_train_done(done_r), .sln_busy(busy_r),
    .sln_wr_en(wr_en), .sln_wr_addr(wr_addr), .sln_wr_data(wr_data));

  seq_learning_neuron #(.N(N), .W(W), .FRAC(FRAC), .ACT_RELU(0), .LRS_W(LRS_W)) dut_i (
    .sln_clock(clk), .sln_reset_n(rst_n), .sln_dendrites(dendrites),
    .sln_fwd_start(fwd_start), .sln_axon(axon_i), .sln_axon_valid(valid_i),
    .sln_backprop(backprop), .sln_lr_shift(lr_shift), .sln_train_start(train_start),
    .sln_backprop_change(chg_i), .sln_train_done(done_i), .sln_busy(busy_i),
    .sln_wr_en(wr_en), .sln_wr_addr(wr_addr), .sln_wr_data(wr_data));

  // Reference model state
  longint w_m   [0:N];
  longint x_m   [0:N-1];
  longint chg_m [0:N-1];
  longint x_in  [0:N-1];
  int     n_checks = 0;
  int     n_fail   = 0;

  function automatic longint sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint rnd(input longint lo, input longint hi);
    return longint'($urandom_range(int'(hi - lo), 0)) + lo;
  endfunction

  function automatic longint model_fwd(input bit relu);
    longint acc, s;
    acc = 0;
    for (int i = 0; i < N; i++) acc += (x_m[i] * w_m[i]) >>> FRAC;
    acc += w_m[N];
    s = sat(acc);
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  task automatic model_train(input longint err, input int s);
    for (int i = 0; i < N; i++) begin
      chg_m[i] = sat((w_m[i] * err) >>> FRAC);
      w_m[i]   = sat(w_m[i] - ((x_m[i] * err) >>> (FRAC + s)));
    end
    w_m[N] = sat(w_m[N] - (err >>> s));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int a, input longint d);
    logic [63:0] dv;
    dv      = d;
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = dv[W-1:0];
    tick();
    wr_en = 1'b0;
    if (a <= N) w_m[a] = d;
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    fwd_start   = 1'b0;
    train_start = 1'b0;
    wr_en       = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i <= N; i++) w_m[i] = 0;
    for (int i = 0; i < N; i++) begin
      x_m[i]   = 0;
      chg_m[i] = 0;
    end
  endtask

  // Runs one forward pass on x_in; with_train also raises train_start on the start edge.
  task automatic run_fwd(input string tag, input bit with_train);
    longint      e_relu, e_id;
    logic [63:0] v;
    int          cnt;
    bit          got, saw_done;
    for (int i = 0; i < N; i++) begin
      v = x_in[i];
      dendrites[i*W +: W] = v[W-1:0];
    end
    fwd_start   = 1'b1;
    train_start = with_train;
    backprop    = W'($urandom);
    tick();
    fwd_start   = 1'b0;
    train_start = 1'b0;
    dendrites   = {N{16'($urandom)}};
    for (int i = 0; i < N; i++) x_m[i] = x_in[i];
    e_relu = model_fwd(1'b1);
    e_id   = model_fwd(1'b0);
    n_checks++;
    if (busy_r !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_after_start: got %b want 1", tag, busy_r);
    end
    got = 0;
    saw_done = 0;
    cnt = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      tick();
      cnt = c;
      if (done_r) saw_done = 1;
      if (valid_r) got = 1;
    end
    n_checks++;
    if (!got || cnt != LAT) begin
      n_fail++;
      $display("FAIL %s valid_latency: got %0d (seen=%0b) want %0d", tag, cnt, got, LAT);
    end
    v = e_relu;
    n_checks++;
    if (axon_r !== v[W-1:0]) begin
      n_fail++;
      $display("FAIL %s axon_relu: got %0d want %0d", tag, $signed(axon_r), e_relu);
    end
    v = e_id;
    n_checks++;
    if (axon_i !== v[W-1:0] || valid_i !== 1'b1) begin
      n_fail++;
      $display("FAIL %s axon_identity: got %0d valid %b want %0d", tag, $signed(axon_i), valid_i, e_id);
    end
    tick();
    if (done_r) saw_done = 1;
    n_checks++;
    if (valid_r !== 1'b0 || busy_r !== 1'b0 || saw_done) begin
      n_fail++;
      $display("FAIL %s pulse_end: valid %b busy %b done_seen %0b want 0 0 0", tag, valid_r, busy_r, saw_done);
    end
  endtask

  task automatic run_train(input string tag, input longint err, input int s);
    logic [63:0] v;
    int          cnt;
    bit          got, saw_valid;
    v           = err;
    backprop    = v[W-1:0];
    lr_shift    = LRS_W'(s);
    train_start = 1'b1;
    tick();
    train_start = 1'b0;
    backprop    = W'($urandom);
    lr_shift    = LRS_W'($urandom);
    model_train(err, s);
    got = 0;
    saw_valid = 0;
    cnt = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      tick();
      cnt = c;
      if (valid_r) saw_valid = 1;
      if (done_r) got = 1;
    end
    n_checks++;
    if (!got || cnt != LAT || saw_valid) begin
      n_fail++;
      $display("FAIL %s done_latency: got %0d (seen=%0b valid=%0b) want %0d", tag, cnt, got, saw_valid, LAT);
    end
    for (int i = 0; i < N; i++) begin
      v = chg_m[i];
      n_checks++;
      if (chg_r[i*W +: W] !== v[W-1:0]) begin
        n_fail++;
        $display("FAIL %s backprop_change[%0d]: got %0d want %0d", tag, i, $signed(chg_r[i*W +: W]), chg_m[i]);
      end
    end
    tick();
    n_checks++;
    if (done_r !== 1'b0 || busy_r !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_pulse_end: done %b busy %b want 0 0", tag, done_r, busy_r);
    end
  endtask

  task automatic load_scenario2();
    write_w(0, 256);
    write_w(1, 512);
    write_w(2, -256);
    write_w(3, 0);
    write_w(4, 128);
    for (int i = 0; i < N; i++) x_in[i] = 256;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (axon_r !== '0 || valid_r !== 1'b0 || done_r !== 1'b0 || busy_r !== 1'b0 || chg_r !== '0) begin
      n_fail++;
      $display("FAIL reset_state: axon %h valid %b done %b busy %b chg %h want all 0", axon_r, valid_r, done_r, busy_r, chg_r);
    end
    load_scenario2();
    run_fwd("reset_pre_fwd", 1'b0);
    run_train("reset_pre_train", 256, 2);
    for (int i = 0; i < N; i++) x_in[i] = rnd(-3000, 3000);
    dendrites = {N{16'h0100}};
    fwd_start = 1'b1;
    tick();
    fwd_start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (axon_r !== '0 || valid_r !== 1'b0 || done_r !== 1'b0 || busy_r !== 1'b0 || chg_r !== '0) begin
      n_fail++;
      $display("FAIL reset_midpass: axon %h valid %b done %b busy %b chg %h want all 0", axon_r, valid_r, done_r, busy_r, chg_r);
    end
    apply_reset();
    for (int i = 0; i < N; i++) x_in[i] = rnd(-30000, 30000);
    run_fwd("reset_post_fwd", 1'b0);
    n_checks++;
    if (axon_i !== '0) begin
      n_fail++;
      $display("FAIL reset_weights_cleared: got %0d want 0", $signed(axon_i));
    end
  endtask

  task automatic test_forward();
    apply_reset();
    load_scenario2();
    run_fwd("fwd_basic", 1'b0);
    n_checks++;
    if (axon_r !== 16'd640) begin
      n_fail++;
      $display("FAIL fwd_basic_const: got %0d want 640", $signed(axon_r));
    end
  endtask

  task automatic test_activation();
    apply_reset();
    write_w(0, -1024);
    x_in[0] = 256;
    for (int i = 1; i < N; i++) x_in[i] = rnd(-2000, 2000);
    run_fwd("activation", 1'b0);
    n_checks++;
    if (axon_r !== 16'h0000 || axon_i !== 16'hFC00) begin
      n_fail++;
      $display("FAIL activation_const: relu %h identity %h want 0000 FC00", axon_r, axon_i);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i <= N; i++) write_w(i, 32767);
    for (int i = 0; i < N; i++) x_in[i] = 32767;
    run_fwd("sat_pos", 1'b0);
    for (int i = 0; i <= N; i++) write_w(i, -32768);
    run_fwd("sat_neg", 1'b0);
    n_checks++;
    if (axon_i !== 16'h8000 || axon_r !== 16'h0000) begin
      n_fail++;
      $display("FAIL sat_neg_const: identity %h relu %h want 8000 0000", axon_i, axon_r);
    end
  endtask

  task automatic test_training();
    apply_reset();
    load_scenario2();
    run_fwd("train_setup", 1'b0);
    run_train("train_basic", 256, 2);
    n_checks++;
    if (chg_r !== {16'd0, 16'hFF00, 16'd512, 16'd256}) begin
      n_fail++;
      $display("FAIL train_change_const: got %h want 0000ff0002000100", chg_r);
    end
    run_fwd("train_refwd", 1'b0);
    n_checks++;
    if (axon_r !== 16'd320) begin
      n_fail++;
      $display("FAIL train_refwd_const: got %0d want 320", $signed(axon_r));
    end
    // Training straight after reset sees zero inputs, so only the bias moves.
    apply_reset();
    for (int i = 0; i <= N; i++) write_w(i, rnd(-4000, 4000));
    run_train("train_no_fwd", rnd(-2000, 2000), int'($urandom_range(4, 0)));
    for (int i = 0; i < N; i++) x_in[i] = rnd(-2000, 2000);
    run_fwd("train_no_fwd_check", 1'b0);
  endtask

  task automatic test_arbitration();
    int  extra_v, extra_d;
    apply_reset();
    load_scenario2();
    run_fwd("arb_both_start", 1'b1);
    for (int i = 0; i < N; i++) x_in[i] = rnd(-1000, 1000);
    for (int i = 0; i < N; i++) dendrites[i*W +: W] = W'(x_in[i]);
    fwd_start = 1'b1;
    tick();
    fwd_start = 1'b0;
    for (int i = 0; i < N; i++) x_m[i] = x_in[i];
    tick();
    fwd_start   = 1'b1;
    train_start = 1'b1;
    wr_en       = 1'b1;
    wr_addr     = '0;
    wr_data     = 16'd9999;
    tick();
    fwd_start   = 1'b0;
    train_start = 1'b0;
    wr_en       = 1'b0;
    extra_v = 0;
    extra_d = 0;
    for (int c = 0; c < 3 * LAT; c++) begin
      tick();
      if (valid_r) extra_v++;
      if (done_r) extra_d++;
    end
    n_checks++;
    if (extra_v != 1 || extra_d != 0) begin
      n_fail++;
      $display("FAIL arb_busy_ignored: valid pulses %0d done pulses %0d want 1 0", extra_v, extra_d);
    end
    run_fwd("arb_weights_kept", 1'b0);
    write_w(N + 1, 16'sd12345);
    write_w(N + 2, -16'sd777);
    run_fwd("arb_addr_oob", 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      if (it % 6 == 0) begin
        for (int i = 0; i <= N; i++) write_w(i, rnd(-6000, 6000));
      end
      for (int i = 0; i < N; i++) x_in[i] = rnd(-8000, 8000);
      run_fwd("rand_fwd", 1'b0);
      if (it % 3 == 1) begin
        run_train("rand_train", rnd(-32768, 32767), int'($urandom_range(15, 0)));
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    dendrites   = '0;
    fwd_start   = 1'b0;
    train_start = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    backprop    = '0;
    lr_shift    = '0;
    for (int i = 0; i < N; i++) x_in[i] = 0;
    test_reset();
    test_forward();
    test_activation();
    test_saturation();
    test_training();
    test_arbitration();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
